// File: rtl/product_accumulator_if.sv
// ----------------------------------------------------------------------------
// product_accumulator_if
// Handshake bundle for product_accumulator.
//   in_valid  : upstream has a valid signed product on P
//   in_ready  : accumulator accepts a product this cycle
//   P         : 32-bit signed Q16.16 product from the 16x16 multiplier
//   out_valid : result/overflow are valid
//   out_ready : consumer takes the result
//   result    : 16-bit signed Q8.8 rounded, saturated sum
//   overflow  : result was saturated (valid with out_valid)
//   busy      : accumulator is not idle
// master drives products and consumes results; slave is the accumulator.
// ----------------------------------------------------------------------------
interface product_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] P;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        busy;

    modport master (
        output in_valid,
        output P,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  overflow,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  P,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output overflow,
        output busy
    );
endinterface

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
// Sums N_TERMS signed Q16.16 products in a 40-bit accumulator, then rounds
// (half up) and shifts right by FRAC_BITS, saturating to a signed 16-bit
// Q8.8 result held until the consumer takes it.
//   CLK   : clock, all state updates on the rising edge
//   RST_N : synchronous active-low reset
//   bus   : handshake bundle (slave side), see product_accumulator_if
// ----------------------------------------------------------------------------
module product_accumulator #(
    parameter int unsigned N_TERMS   = 2,
    parameter int unsigned FRAC_BITS = 8
) (
    input logic                  CLK,
    input logic                  RST_N,
    product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StRound,
        StHold
    } state_e;

    localparam logic        [7:0]  NTermsC   = 8'(N_TERMS);
    localparam logic signed [39:0] RoundBias = 40'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [39:0] SatMax    = 40'sd32767;
    localparam logic signed [39:0] SatMin    = -40'sd32768;

    state_e             state_q, state_d;
    logic signed [39:0] acc_q, acc_d;
    logic        [7:0]  count_q, count_d;
    logic        [15:0] result_q, result_d;
    logic               overflow_q, overflow_d;

    logic signed [39:0] p_ext;
    logic signed [39:0] rounded;
    logic signed [39:0] r_shift;
    logic               accept;

    assign bus.in_ready  = (state_q == StIdle) || (state_q == StAccum);
    assign bus.out_valid = (state_q == StHold);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        p_ext      = $signed({{8{bus.P[31]}}, bus.P});
        // 40 bits leave headroom for 255 * 2^31 plus the rounding bias.
        rounded    = acc_q + RoundBias;
        r_shift    = rounded >>> FRAC_BITS;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d   = p_ext;
                    count_d = 8'd1;
                    state_d = (N_TERMS == 1) ? StRound : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d   = acc_q + p_ext;
                    count_d = count_q + 8'd1;
                    if (count_d == NTermsC) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                if (r_shift > SatMax) begin
                    result_d   = 16'h7FFF;
                    overflow_d = 1'b1;
                end else if (r_shift < SatMin) begin
                    result_d   = 16'h8000;
                    overflow_d = 1'b1;
                end else begin
                    result_d   = r_shift[15:0];
                    overflow_d = 1'b0;
                end
                state_d = StHold;
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            count_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
